// File: rtl/cpu_param.sv
// cpu_param: parametrised multi-cycle CPU core with a single ready-handshaked
// memory bus, four general registers, Z/C flags, conditional jumps and halt.
// Optional feature macro: CPU_BUS_TIMEOUT_EN adds a bus watchdog that aborts a
// stuck transfer, raises a sticky bus_err and halts the core.
module cpu_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int RESET_IP = 0,
  parameter int TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic              ready,
  output logic              read,
  output logic              write,
  output logic              halted
`ifdef CPU_BUS_TIMEOUT_EN
  ,
  output logic              bus_err
`endif
);

  typedef enum logic [2:0] {BOOT, FETCH, DECODE, OPND, MEM, EXEC, HALT} state_t;

  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_MOV = 4'h4;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_AND = 4'h7;
  localparam logic [3:0] OP_OR  = 4'h8;
  localparam logic [3:0] OP_XOR = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_JZ  = 4'hB;
  localparam logic [3:0] OP_JC  = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t            state;
  logic [7:0]        cmd;
  logic [DATA_W-1:0] regs [4];
  logic [DATA_W-1:0] operand;
  logic [ADDR_W-1:0] ip;
  logic              zf;
  logic              cf;

  logic [3:0]        op;
  logic [1:0]        rd;
  logic [1:0]        rs;
  logic [DATA_W:0]   alu_full;
  logic              alu_op;
  logic [ADDR_W-1:0] exec_ip;

  assign op = cmd[7:4];
  assign rd = cmd[3:2];
  assign rs = cmd[1:0];

  // Register values used as addresses are zero-extended or truncated to ADDR_W.
  function automatic logic [ADDR_W-1:0] to_addr(input logic [DATA_W-1:0] v);
    logic [DATA_W+ADDR_W-1:0] wide;
    wide = {{ADDR_W{1'b0}}, v};
    return wide[ADDR_W-1:0];
  endfunction

  // ALU result with the carry/borrow in the extra top bit; logic ops leave it 0.
  always_comb begin
    alu_full = '0;
    alu_op   = 1'b1;
    case (op)
      OP_ADD:  alu_full = {1'b0, regs[rd]} + {1'b0, regs[rs]};
      OP_SUB:  alu_full = {1'b0, regs[rd]} - {1'b0, regs[rs]};
      OP_AND:  alu_full = {1'b0, regs[rd] & regs[rs]};
      OP_OR:   alu_full = {1'b0, regs[rd] | regs[rs]};
      OP_XOR:  alu_full = {1'b0, regs[rd] ^ regs[rs]};
      default: alu_op   = 1'b0;
    endcase
  end

  // Instruction pointer after EXEC: jump target when taken, else already past the operand.
  always_comb begin
    exec_ip = ip;
    case (op)
      OP_JMP:  exec_ip = to_addr(operand);
      OP_JZ:   if (zf) exec_ip = to_addr(operand);
      OP_JC:   if (cf) exec_ip = to_addr(operand);
      default: exec_ip = ip;
    endcase
  end

`ifdef CPU_BUS_TIMEOUT_EN
  logic [31:0] wait_cnt;
  logic        timeout_hit;

  assign timeout_hit = (read || write) && !ready && (wait_cnt == 32'(TIMEOUT - 1));

  // Watchdog counts cycles of the current request; idle cycles restart it.
  always_ff @(posedge clk) begin
    if (reset || !(read || write)) wait_cnt <= '0;
    else                           wait_cnt <= wait_cnt + 32'd1;
  end
`endif

  // Main FSM: state, architectural registers and registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BOOT;
      cmd      <= '0;
      operand  <= '0;
      ip       <= ADDR_W'(RESET_IP);
      zf       <= 1'b0;
      cf       <= 1'b0;
      address  <= '0;
      data_out <= '0;
      read     <= 1'b0;
      write    <= 1'b0;
      halted   <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
`ifdef CPU_BUS_TIMEOUT_EN
      bus_err  <= 1'b0;
`endif
    end
`ifdef CPU_BUS_TIMEOUT_EN
    else if (timeout_hit) begin
      read     <= 1'b0;
      write    <= 1'b0;
      data_out <= '0;
      halted   <= 1'b1;
      bus_err  <= 1'b1;
      state    <= HALT;
    end
`endif
    else begin
      case (state)
        BOOT: begin
          state   <= FETCH;
          read    <= 1'b1;
          address <= ip;
        end
        FETCH: begin
          if (ready) begin
            cmd   <= data_in[7:0];
            ip    <= ip + ADDR_W'(1);
            read  <= 1'b0;
            state <= DECODE;
          end
        end
        DECODE: begin
          case (op)
            OP_LDI, OP_JMP, OP_JZ, OP_JC: begin
              state   <= OPND;
              read    <= 1'b1;
              address <= ip;
            end
            OP_LD: begin
              state   <= MEM;
              read    <= 1'b1;
              address <= to_addr(regs[rs]);
            end
            OP_ST: begin
              state    <= MEM;
              write    <= 1'b1;
              address  <= to_addr(regs[rd]);
              data_out <= regs[rs];
            end
            OP_HLT: begin
              state  <= HALT;
              halted <= 1'b1;
            end
            default: state <= EXEC;
          endcase
        end
        OPND: begin
          if (ready) begin
            operand <= data_in;
            ip      <= ip + ADDR_W'(1);
            read    <= 1'b0;
            state   <= EXEC;
          end
        end
        MEM: begin
          if (ready) begin
            if (op == OP_LD) operand <= data_in;
            read     <= 1'b0;
            write    <= 1'b0;
            data_out <= '0;
            state    <= EXEC;
          end
        end
        EXEC: begin
          case (op)
            OP_LDI, OP_LD: regs[rd] <= operand;
            OP_MOV:        regs[rd] <= regs[rs];
            default: begin
              if (alu_op) begin
                regs[rd] <= alu_full[DATA_W-1:0];
                zf       <= (alu_full[DATA_W-1:0] == '0);
                cf       <= alu_full[DATA_W];
              end
            end
          endcase
          ip      <= exec_ip;
          address <= exec_ip;
          read    <= 1'b1;
          state   <= FETCH;
        end
        HALT: state <= HALT;
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_param.sv
// tb_cpu_param: scoreboard bench for cpu_param. Stimulus loads directed
// programs into a bench memory and queues the hand-computed bus transfers;
// a monitor pops and compares each completed transfer.
// With CPU_BUS_TIMEOUT_EN defined the bus watchdog scenario is also run.
module tb_cpu_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] address;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       ready = 1'b0;
  logic       read;
  logic       write;
  logic       halted;
`ifdef CPU_BUS_TIMEOUT_EN
  logic       bus_err;
`endif

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
    int         len;
  } xfer_t;

  xfer_t      exp_q[$];
  xfer_t      mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] mem [256];
  bit         ready_default = 1'b1;
  bit         hold_writes = 1'b0;
  logic [7:0] stall_addr = 8'h00;
  int         stall_left = 0;
  int         cur_len = 0;
  logic [7:0] start_addr;
  logic [7:0] start_data;
  logic [31:0] unstable;

  cpu_param dut (
    .clk      (clk),
    .reset    (reset),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out),
    .ready    (ready),
    .read     (read),
    .write    (write),
    .halted   (halted)
`ifdef CPU_BUS_TIMEOUT_EN
    ,
    .bus_err  (bus_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushRead(input logic [7:0] a, input int len = 1);
    xfer_t e;
    e.wr = 1'b0; e.addr = a; e.data = 8'h00; e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic pushWrite(input logic [7:0] a, input logic [7:0] d);
    xfer_t e;
    e.wr = 1'b1; e.addr = a; e.data = d; e.len = 1;
    exp_q.push_back(e);
  endtask

  task automatic pushReads(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) pushRead(first + 8'(i));
  endtask

  // Unused locations hold HLT so a runaway core stops quickly.
  task automatic clearMem;
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
  endtask

  task automatic applyStimulus;
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic runToHalt(input string name);
    int n;
    n = 0;
    while (!halted && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_halted"}, 32'(halted), 1);
    repeat (3) @(negedge clk);
    checkOutput({name, "_bus_idle"}, {30'd0, read, write}, 0);
    checkOutput({name, "_queue_empty"}, 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  // Memory slave: decides ready/data_in for the coming edge, with optional stalls.
  always @(posedge clk) begin
    #1;
    if (read && address == stall_addr && stall_left > 0) begin
      ready   = 1'b0;
      data_in = 8'hEE;
      stall_left--;
    end else if (write && hold_writes) begin
      ready = 1'b0;
    end else begin
      ready   = ready_default;
      data_in = read ? mem[address] : 8'h00;
    end
  end

  // Monitor: tracks each request and scores it against the queue when it completes.
  always @(negedge clk) begin
    if (reset) begin
      cur_len = 0;
    end else if (read || write) begin
      if (cur_len == 0) begin
        start_addr = address;
        start_data = data_out;
        unstable   = 0;
      end else if (address !== start_addr || data_out !== start_data) begin
        unstable = 1;
      end
      cur_len++;
      if (ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_xfer: got wr=%0d addr=0x%0h, required no transfer", write, address);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("xfer_kind", 32'(write), 32'(mon_e.wr));
          checkOutput("xfer_addr", 32'(address), 32'(mon_e.addr));
          if (mon_e.wr) checkOutput("xfer_wdata", 32'(data_out), 32'(mon_e.data));
          else          checkOutput("xfer_rd_dout_zero", 32'(data_out), 0);
          checkOutput("xfer_len", 32'(cur_len), 32'(mon_e.len));
          checkOutput("xfer_stable", unstable, 0);
          checkOutput("xfer_rw_excl", 32'(read & write), 0);
        end
        cur_len = 0;
      end
    end else begin
      cur_len = 0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;

    // Program 1: LDI/LDI/ADD wraps to zero, JZ taken, LDI, ST, HLT.
    clearMem;
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h05;
    mem[8'h02] = 8'h14; mem[8'h03] = 8'hFB;
    mem[8'h04] = 8'h51;
    mem[8'h05] = 8'hB0; mem[8'h06] = 8'h20;
    mem[8'h20] = 8'h18; mem[8'h21] = 8'h40;
    mem[8'h22] = 8'h38;
    mem[8'h23] = 8'hF0;
    pushReads(8'h00, 7);
    pushReads(8'h20, 3);
    pushWrite(8'h40, 8'h00);
    pushRead(8'h23);
    ready_default = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("boot_read", 32'(read), 0);
    checkOutput("boot_write", 32'(write), 0);
    checkOutput("boot_address", 32'(address), 0);
    checkOutput("boot_data_out", 32'(data_out), 0);
    checkOutput("boot_halted", 32'(halted), 0);
`ifdef CPU_BUS_TIMEOUT_EN
    checkOutput("boot_bus_err", 32'(bus_err), 0);
`endif
    @(negedge clk);
    checkOutput("fetch_read", 32'(read), 1);
    checkOutput("fetch_address", 32'(address), 0);
    checkOutput("fetch_write", 32'(write), 0);
    runToHalt("prog1");

    // Program 2: 3 - 5 borrows (C=1) and wraps to 0xFE; JC taken to 0x30 stores r0.
    clearMem;
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h03;
    mem[8'h02] = 8'h14; mem[8'h03] = 8'h05;
    mem[8'h04] = 8'h61;
    mem[8'h05] = 8'hC0; mem[8'h06] = 8'h30;
    mem[8'h30] = 8'h34;
    mem[8'h31] = 8'hF0;
    pushReads(8'h00, 7);
    pushRead(8'h30);
    pushWrite(8'h05, 8'hFE);
    pushRead(8'h31);
    applyStimulus;
    runToHalt("prog2");

    // Program 3: stalled LD, ST of loaded value, XOR clears C and sets Z,
    // JC not taken, JZ taken, MOV, ST, reserved opcode, HLT.
    clearMem;
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h80;
    mem[8'h02] = 8'h24;
    mem[8'h03] = 8'h31;
    mem[8'h04] = 8'h95;
    mem[8'h05] = 8'hC0; mem[8'h06] = 8'h40;
    mem[8'h07] = 8'hB0; mem[8'h08] = 8'h50;
    mem[8'h50] = 8'h44;
    mem[8'h51] = 8'h35;
    mem[8'h52] = 8'hD0;
    mem[8'h53] = 8'hF0;
    mem[8'h80] = 8'h5A;
    pushReads(8'h00, 3);
    pushRead(8'h80, 6);
    pushRead(8'h03);
    pushWrite(8'h80, 8'h5A);
    pushReads(8'h04, 5);
    pushReads(8'h50, 2);
    pushWrite(8'h80, 8'h80);
    pushReads(8'h52, 2);
    stall_addr = 8'h80;
    stall_left = 5;
    applyStimulus;
    runToHalt("prog3");
    stall_left = 0;

    // Program 4: reset lands while a store waits for ready.
    clearMem;
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h40;
    mem[8'h02] = 8'h30;
    pushReads(8'h00, 3);
    hold_writes = 1'b1;
    applyStimulus;
    n = 0;
    while (!write && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rst_write_seen", 32'(write), 1);
    checkOutput("rst_write_addr", 32'(address), 32'h40);
    checkOutput("rst_write_data", 32'(data_out), 32'h40);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_write_drop", 32'(write), 0);
    checkOutput("rst_read_low", 32'(read), 0);
    checkOutput("rst_address_zero", 32'(address), 0);
    checkOutput("rst_queue_empty", 32'(exp_q.size()), 0);
    hold_writes = 1'b0;
    mem[8'h00] = 8'hF0;
    pushRead(8'h00);
    reset = 1'b0;
    runToHalt("prog4");

`ifdef CPU_BUS_TIMEOUT_EN
    // Bus never answers: watchdog aborts the first fetch after 15 request cycles.
    clearMem;
    ready_default = 1'b0;
    applyStimulus;
    n = 0;
    for (int i = 0; i < 100 && !halted; i++) begin
      @(negedge clk);
      if (read) n++;
    end
    checkOutput("to_read_cycles", 32'(n), 15);
    checkOutput("to_bus_err", 32'(bus_err), 1);
    runToHalt("timeout");
    checkOutput("to_bus_err_sticky", 32'(bus_err), 1);
    ready_default = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
